// File: rtl/freq_tracker.sv
// Perturb-and-observe frequency tracker for the SWIPT link.
// Steps the switching period up or down after each measurement window
// and keeps the direction that raises the mean coil current. It reports
// lock once the search keeps reversing around the optimum.
module freq_tracker #(
    parameter int PERIOD_W      = 12,
    parameter int PERIOD_INIT   = 400,
    parameter int PERIOD_MIN    = 300,
    parameter int PERIOD_MAX    = 500,
    parameter int STEP          = 4,
    parameter int SETTLE_CYCLES = 1000,
    parameter int MEAS_CYCLES   = 40000,
    parameter int LOCK_REV      = 2
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                swiptAlive,
    input  logic [11:0]         mean_curr,
    output logic                measure,
    output logic [PERIOD_W-1:0] period,
    output logic                step_dir,
    output logic                locked,
    output logic                eval_strobe
);

    localparam int CNT_MAX = (SETTLE_CYCLES > MEAS_CYCLES) ? SETTLE_CYCLES : MEAS_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int REV_W   = $clog2(LOCK_REV + 1);
    localparam int SUM_W   = PERIOD_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEAS,
        WAIT,
        EVAL
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;

    logic [11:0]       prev_curr;
    logic              first;
    logic [REV_W-1:0]  rev_cnt;

    logic              restart;
    logic              dir_eval;
    logic              dir_final;
    logic [REV_W-1:0]  rev_eval;
    logic              locked_eval;
    logic [SUM_W-1:0]  sum;
    logic              under;
    logic [PERIOD_W-1:0] period_eval;

    // Losing the link is handled exactly like a reset.
    assign restart = !nrst || !swiptAlive;

    // State register and the shared settle/measure phase counter.
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop
        // samples the values from before this edge, whatever the order
        // of the statements.
        if (restart) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic and the state-decoded strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the case leaves one unassigned and infers a latch.
        state_next  = state;
        cnt_next    = cnt;
        measure     = 1'b0;
        eval_strobe = 1'b0;
        case (state)
            IDLE: begin
                state_next = SETTLE;
                cnt_next   = '0;
            end
            SETTLE: begin
                if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_next = MEAS;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            MEAS: begin
                measure = 1'b1;
                if (cnt == CNT_W'(MEAS_CYCLES - 1)) begin
                    state_next = WAIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            WAIT: begin
                // Gives the measurement stage one cycle to register its
                // final sample.
                state_next = EVAL;
            end
            EVAL: begin
                eval_strobe = 1'b1;
                state_next  = SETTLE;
                cnt_next    = '0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Direction, reversal count and the clamped next period for an evaluation.
    always_comb begin
        dir_eval    = step_dir;
        rev_eval    = rev_cnt;
        locked_eval = locked;
        // The first evaluation after a restart has no previous sample to
        // compare against, so it only steps in the current direction.
        if (!first) begin
            if (mean_curr >= prev_curr) begin
                rev_eval    = '0;
                locked_eval = 1'b0;
            end else begin
                dir_eval = ~step_dir;
                if (rev_cnt < REV_W'(LOCK_REV)) begin
                    rev_eval = rev_cnt + 1'b1;
                end
                locked_eval = (rev_eval >= REV_W'(LOCK_REV));
            end
        end

        if (dir_eval) begin
            sum = {1'b0, period} + SUM_W'(STEP);
        end else begin
            sum = {1'b0, period} - SUM_W'(STEP);
        end
        // A borrow out of the subtraction shows up as the extra top bit.
        under = ~dir_eval & sum[PERIOD_W];

        period_eval = sum[PERIOD_W-1:0];
        dir_final   = dir_eval;
        // Clamping turns the search around but does not count as a reversal.
        if (under || (sum < SUM_W'(PERIOD_MIN))) begin
            period_eval = PERIOD_W'(PERIOD_MIN);
            dir_final   = 1'b1;
        end else if (sum > SUM_W'(PERIOD_MAX)) begin
            period_eval = PERIOD_W'(PERIOD_MAX);
            dir_final   = 1'b0;
        end
    end

    // Tracker state: updated only on an evaluation cycle or a restart.
    always_ff @(posedge clk) begin
        if (restart) begin
            period    <= PERIOD_W'(PERIOD_INIT);
            step_dir  <= 1'b1;
            locked    <= 1'b0;
            prev_curr <= '0;
            first     <= 1'b1;
            rev_cnt   <= '0;
        end else if (state == EVAL) begin
            period    <= period_eval;
            step_dir  <= dir_final;
            locked    <= locked_eval;
            rev_cnt   <= rev_eval;
            prev_curr <= mean_curr;
            first     <= 1'b0;
        end
    end

endmodule
